// File: rtl/prio_scan_encoder_pkg.sv
// Shared definitions for the priority scan encoder family: the scan FSM
// state type, the priority-direction encodings and a width helper.
package prio_pkg;

    // Scan controller states: waiting for a start pulse, or draining a mask.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Priority direction encodings for the MSB_FIRST parameter.
    localparam bit PRIO_MSB_FIRST = 1'b1;
    localparam bit PRIO_LSB_FIRST = 1'b0;

    // Ceiling log2, used to size index ports from the request width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int w = value - 1; w > 0; w = w >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Purely combinational N-input priority encoder. Returns the index of the
// highest-priority set bit and a flag saying whether any bit was set.
// Shared with the standalone combinational encoder, so it has no clock.
module prio_enc_comb
    import prio_pkg::*;
#(
    parameter int N = 16,
    parameter bit MSB_FIRST = PRIO_MSB_FIRST,
    localparam int IDXW = clog2(N)
) (
    input  logic [N-1:0]    vec,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // Walk the vector towards the priority end so the last hit wins.
    always_comb begin
        idx = '0;
        any = |vec;
        if (MSB_FIRST == PRIO_MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    idx = IDXW'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prio_scan_encoder.sv
// Sequential priority scanner. A start pulse captures the request vector;
// every set bit is then presented, one per valid/ready handshake, in
// priority order. All outputs come from registered state only, so neither
// req nor out_ready reaches an output combinationally.
module prio_scan_encoder
    import prio_pkg::*;
#(
    parameter int N = 16,
    parameter bit MSB_FIRST = PRIO_MSB_FIRST,
    localparam int IDXW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N-1:0]    req,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic [IDXW:0]   pending,
    output logic            busy,
    output logic            none,
    output logic            done
);

    localparam logic [IDXW:0] PENDING_ONE = (IDXW+1)'(1);
    localparam logic [N-1:0]  BIT_ZERO    = {{(N-1){1'b0}}, 1'b1};

    scan_state_t     state_q;
    scan_state_t     state_d;
    logic [N-1:0]    mask_q;
    logic [IDXW:0]   pending_q;
    logic            none_q;
    logic            done_q;
    logic [IDXW-1:0] enc_idx;
    logic            enc_any;
    logic            in_scan;
    logic            final_pending;
    logic            handshake;
    logic            start_load;
    logic            start_empty;
    logic [N-1:0]    select_mask;

    // Number of set bits in a request vector; IDXW+1 bits always hold N.
    function automatic logic [IDXW:0] popcount(input logic [N-1:0] v);
        logic [IDXW:0] count;
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + {{IDXW{1'b0}}, v[i]};
        end
        return count;
    endfunction

    // Priority pick over the bits still outstanding in the captured mask.
    prio_enc_comb #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .vec (mask_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Decode the events that move the controller and the datapath.
    always_comb begin
        in_scan       = (state_q == SCAN);
        final_pending = (pending_q == PENDING_ONE);
        handshake     = in_scan && out_ready;
        start_load    = (state_q == IDLE) && start && (req != '0);
        start_empty   = (state_q == IDLE) && start && (req == '0);
        select_mask   = BIT_ZERO << enc_idx;
    end

    // State register; reset drops any scan in progress without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter SCAN on a non-empty capture, leave after the last handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (handshake && final_pending) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Mask, pending count and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            pending_q <= '0;
            none_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            none_q <= start_empty;
            done_q <= handshake && final_pending;
            if (start_load) begin
                mask_q    <= req;
                pending_q <= popcount(req);
            end else if (handshake) begin
                mask_q    <= mask_q & ~select_mask;
                pending_q <= pending_q - PENDING_ONE;
            end
        end
    end

    // Output decode; the index is forced to zero whenever nothing is presented.
    always_comb begin
        busy      = in_scan;
        out_valid = in_scan;
        out_idx   = (in_scan && enc_any) ? enc_idx : '0;
        out_last  = in_scan && final_pending;
        pending   = pending_q;
        none      = none_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Self-checking bench for prio_scan_encoder. Two instances (MSB-first and
// LSB-first) share one stimulus stream and are compared every cycle against
// a transaction-level model that lists the expected indices in order.
module tb_prio_scan_encoder;

    localparam int N    = 16;
    localparam int IDXW = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] req = '0;

    logic            m_valid, m_last, m_busy, m_none, m_done;
    logic [IDXW-1:0] m_idx;
    logic [IDXW:0]   m_pending;
    logic            l_valid, l_last, l_busy, l_none, l_done;
    logic [IDXW-1:0] l_idx;
    logic [IDXW:0]   l_pending;

    int checks = 0;
    int failures = 0;

    // Model state per instance: 0 = MSB-first, 1 = LSB-first.
    int exp_list [2][N];
    int exp_cnt  [2];
    int exp_pos  [2];
    bit exp_busy [2];
    bit exp_none [2];
    bit exp_done [2];

    prio_scan_encoder #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req       (req),
        .out_valid (m_valid),
        .out_ready (out_ready),
        .out_idx   (m_idx),
        .out_last  (m_last),
        .pending   (m_pending),
        .busy      (m_busy),
        .none      (m_none),
        .done      (m_done)
    );

    prio_scan_encoder #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req       (req),
        .out_valid (l_valid),
        .out_ready (out_ready),
        .out_idx   (l_idx),
        .out_last  (l_last),
        .pending   (l_pending),
        .busy      (l_busy),
        .none      (l_none),
        .done      (l_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks = checks + 1;
        if (observed != expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            exp_cnt[d]  = 0;
            exp_pos[d]  = 0;
            exp_busy[d] = 1'b0;
            exp_none[d] = 1'b0;
            exp_done[d] = 1'b0;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic modelUpdate();
        int bit_index;
        for (int d = 0; d < 2; d++) begin
            exp_none[d] = 1'b0;
            exp_done[d] = 1'b0;
            if (exp_busy[d]) begin
                if (out_ready) begin
                    exp_pos[d] = exp_pos[d] + 1;
                    if (exp_pos[d] == exp_cnt[d]) begin
                        exp_busy[d] = 1'b0;
                        exp_done[d] = 1'b1;
                    end
                end
            end else if (start) begin
                if (req != '0) begin
                    exp_cnt[d] = 0;
                    exp_pos[d] = 0;
                    for (int k = 0; k < N; k++) begin
                        bit_index = (d == 0) ? (N - 1 - k) : k;
                        if (req[bit_index]) begin
                            exp_list[d][exp_cnt[d]] = bit_index;
                            exp_cnt[d] = exp_cnt[d] + 1;
                        end
                    end
                    exp_busy[d] = 1'b1;
                end else begin
                    exp_none[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic checkDut(input string pfx, input int d, input logic valid, input logic [IDXW-1:0] idx,
                            input logic last, input logic [IDXW:0] pend, input logic bsy,
                            input logic nn, input logic dn);
        int left;
        left = exp_busy[d] ? (exp_cnt[d] - exp_pos[d]) : 0;
        checkOutput({pfx, ".out_valid"}, int'(valid), int'(exp_busy[d]));
        checkOutput({pfx, ".busy"}, int'(bsy), int'(exp_busy[d]));
        checkOutput({pfx, ".out_idx"}, int'(idx), exp_busy[d] ? exp_list[d][exp_pos[d]] : 0);
        checkOutput({pfx, ".out_last"}, int'(last), (exp_busy[d] && left == 1) ? 1 : 0);
        checkOutput({pfx, ".pending"}, int'(pend), left);
        checkOutput({pfx, ".none"}, int'(nn), int'(exp_none[d]));
        checkOutput({pfx, ".done"}, int'(dn), int'(exp_done[d]));
    endtask

    task automatic checkAll();
        checkDut("msb", 0, m_valid, m_idx, m_last, m_pending, m_busy, m_none, m_done);
        checkDut("lsb", 1, l_valid, l_idx, l_last, l_pending, l_busy, l_none, l_done);
    endtask

    // Drive inputs (called just after a falling edge), clock once, then compare.
    task automatic applyStimulus(input logic s, input logic [N-1:0] r, input logic rdy);
        start     = s;
        req       = r;
        out_ready = rdy;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkAll();
    endtask

    initial begin
        logic [N-1:0] rnd_req;
        int           mode;

        resetModel();
        repeat (2) @(negedge clk);
        checkAll();
        rst_n = 1'b1;

        // Priority order in both directions, pending countdown and done pulse.
        applyStimulus(1'b1, 16'h8101, 1'b1);
        checkOutput("dir_msb_first_idx", int'(m_idx), 15);
        checkOutput("dir_lsb_first_idx", int'(l_idx), 0);
        checkOutput("dir_first_pending", int'(m_pending), 3);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("dir_msb_second_idx", int'(m_idx), 8);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("dir_msb_third_idx", int'(m_idx), 0);
        checkOutput("dir_lsb_third_idx", int'(l_idx), 15);
        checkOutput("dir_last_flag", int'(m_last), 1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("dir_done_pulse", int'(m_done), 1);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Empty capture: a single none pulse and nothing else.
        applyStimulus(1'b1, 16'h0000, 1'b1);
        checkOutput("empty_none_pulse", int'(m_none), 1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("empty_none_clear", int'(m_none), 0);

        // Back-pressure holds the presented index stable.
        applyStimulus(1'b1, 16'h0030, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("stall_idx_held", int'(m_idx), 5);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("stall_next_idx", int'(m_idx), 4);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Start during a scan is ignored; start in the done cycle is taken.
        applyStimulus(1'b1, 16'h8101, 1'b1);
        applyStimulus(1'b1, 16'hFFFF, 1'b1);
        checkOutput("busy_start_ignored_idx", int'(m_idx), 8);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("busy_start_done", int'(m_done), 1);
        applyStimulus(1'b1, 16'h0002, 1'b1);
        checkOutput("done_cycle_start_idx", int'(m_idx), 1);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Asynchronous reset in the middle of a scan.
        applyStimulus(1'b1, 16'hF000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("pre_reset_idx", int'(m_idx), 14);
        #2 rst_n = 1'b0;
        #1;
        resetModel();
        checkAll();
        @(negedge clk);
        checkAll();
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b1, 16'h0101, 1'b1);
        checkOutput("post_reset_idx", int'(m_idx), 8);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            mode = $urandom_range(0, 7);
            if (mode == 0) begin
                rnd_req = '0;
            end else if (mode < 4) begin
                rnd_req = N'($urandom & $urandom & $urandom);
            end else begin
                rnd_req = N'($urandom);
            end
            applyStimulus(($urandom_range(0, 3) == 0), rnd_req, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
